// File: rtl/gaussian_moment_acc.sv
// Batch statistics collector for signed normal samples:
// sum, sum of squares, min and max over 2^N_LOG2 accepted samples.
module gaussian_moment_acc #(
  parameter int SAMPLE_W = 13,
  parameter int N_LOG2   = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [SAMPLE_W-1:0]            in_sample,
  output logic                           busy,
  output logic                           done,
  output logic                           result_valid,
  output logic [SAMPLE_W+N_LOG2-1:0]     sum,
  output logic [2*SAMPLE_W-2+N_LOG2:0]   sumsq,
  output logic [SAMPLE_W-1:0]            s_min,
  output logic [SAMPLE_W-1:0]            s_max
);

  localparam int SUM_W   = SAMPLE_W + N_LOG2;
  localparam int SQ_W    = 2 * SAMPLE_W - 1;
  localparam int SUMSQ_W = SQ_W + N_LOG2;
  localparam int CNT_W   = N_LOG2 + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] FULL =
    {1'b1, {N_LOG2{1'b0}}};
  localparam logic [SAMPLE_W-1:0] POS_MAX =
    {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] NEG_MAX =
    {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                s1_vld_q;
  logic [SAMPLE_W-1:0] s1_smp_q;
  logic [SQ_W-1:0]     s1_sq_q;
  logic [SUM_W-1:0]    sum_q;
  logic [SUMSQ_W-1:0]  sumsq_q;
  logic [SAMPLE_W-1:0] min_q, max_q;
  logic                done_q, rv_q;

  logic                  accept, enter_acc, finish;
  logic [2*SAMPLE_W-1:0] prod_full;
  logic                  prod_unused;
  logic [SQ_W-1:0]       sq;

  assign accept    = (state_q == S_ACC) && in_valid
                     && (cnt_q != FULL);
  assign enter_acc = start && (state_q != S_ACC);
  // Wait for stage 2 to absorb the last sample before finishing.
  assign finish    = (state_q == S_ACC) && (cnt_q == FULL)
                     && !s1_vld_q;

  // A square of a SAMPLE_W-bit value always fits in 2*SAMPLE_W-1 bits.
  assign prod_full   = $signed(in_sample) * $signed(in_sample);
  assign sq          = prod_full[SQ_W-1:0];
  assign prod_unused = prod_full[2*SAMPLE_W-1];

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == S_IDLE): if (start)  state_d = S_ACC;
      (state_q == S_ACC):  if (finish) state_d = S_DONE;
      (state_q == S_DONE): if (start)  state_d = S_ACC;
      default:             state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_smp_q <= '0;
      s1_sq_q  <= '0;
      sum_q    <= '0;
      sumsq_q  <= '0;
      min_q    <= '0;
      max_q    <= '0;
      done_q   <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= finish;
      s1_vld_q <= accept;
      if (finish)         rv_q <= 1'b1;
      else if (enter_acc) rv_q <= 1'b0;
      if (accept) begin
        s1_smp_q <= in_sample;
        s1_sq_q  <= sq;
      end
      if (enter_acc) begin
        cnt_q   <= '0;
        sum_q   <= '0;
        sumsq_q <= '0;
        min_q   <= POS_MAX;
        max_q   <= NEG_MAX;
      end else begin
        if (accept) cnt_q <= cnt_q + 1'b1;
        if (s1_vld_q) begin
          sum_q <= sum_q +
            {{N_LOG2{s1_smp_q[SAMPLE_W-1]}}, s1_smp_q};
          sumsq_q <= sumsq_q + {{N_LOG2{1'b0}}, s1_sq_q};
          if ($signed(s1_smp_q) < $signed(min_q))
            min_q <= s1_smp_q;
          if ($signed(s1_smp_q) > $signed(max_q))
            max_q <= s1_smp_q;
        end
      end
    end
  end

  assign busy         = (state_q == S_ACC);
  assign done         = done_q;
  assign result_valid = rv_q;
  assign sum          = sum_q;
  assign sumsq        = sumsq_q;
  assign s_min        = min_q;
  assign s_max        = max_q;

endmodule

// File: tb/tb_gaussian_moment_acc.sv
// Scoreboard bench for gaussian_moment_acc at N_LOG2=4:
// a behavioural model pushes expected batch results, done pops them.
module tb_gaussian_moment_acc;

  localparam int W     = 13;
  localparam int N     = 4;
  localparam int BATCH = 16;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [W-1:0]  in_sample;
  logic          busy, done, result_valid;
  logic [16:0]   sum;
  logic [28:0]   sumsq;
  logic [W-1:0]  s_min, s_max;

  typedef struct packed {
    logic signed [16:0] sum;
    logic [28:0]        sumsq;
    logic [12:0]        mn;
    logic [12:0]        mx;
    logic [31:0]        edge_n;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];

  int tests = 0, fails = 0;
  int edges = 0, busy_err = 0;
  int mstate = 0, mcnt = 0, mdone_edge = 0;
  longint msum, msumsq;
  int mmin, mmax;

  gaussian_moment_acc #(.SAMPLE_W(W), .N_LOG2(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_sample(in_sample),
    .busy(busy), .done(done),
    .result_valid(result_valid),
    .sum(sum), .sumsq(sumsq),
    .s_min(s_min), .s_max(s_max)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  function automatic string fmt(res_t r);
    return $sformatf("sum=%0d sumsq=%0d min=%h max=%h edge=%0d",
      r.sum, r.sumsq, r.mn, r.mx, r.edge_n);
  endfunction

  // One clock: drive, advance the model, capture done events.
  task automatic step(input logic st, input logic v,
                      input logic [W-1:0] s);
    logic acc, go;
    int sv;
    start = st; in_valid = v; in_sample = s;
    acc = (mstate == 1) && v && (mcnt < BATCH);
    go  = st && (mstate != 1);
    @(posedge clk);
    edges++;
    if (go) begin
      mstate = 1; mcnt = 0; msum = 0; msumsq = 0;
      mmin = 4095; mmax = -4096;
    end
    if (acc) begin
      sv = int'($signed(s));
      mcnt++;
      msum += sv;
      msumsq += longint'(sv * sv);
      if (sv < mmin) mmin = sv;
      if (sv > mmax) mmax = sv;
      if (mcnt == BATCH) begin
        mdone_edge = edges + 2;
        exp_q.push_back('{sum: 17'(msum), sumsq: 29'(msumsq),
          mn: 13'(mmin), mx: 13'(mmax),
          edge_n: 32'(mdone_edge)});
      end
    end
    if (mstate == 1 && mcnt == BATCH && edges == mdone_edge)
      mstate = 2;
    #1;
    if (busy !== (mstate == 1)) busy_err++;
    if (done === 1'b1)
      obs_q.push_back('{sum: sum, sumsq: sumsq, mn: s_min,
        mx: s_max, edge_n: 32'(edges)});
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0);
  endtask

  task automatic wait_obs(output bit ok);
    for (int i = 0; i < 40 && obs_q.size() == 0; i++) idle(1);
    ok = (obs_q.size() != 0) && (exp_q.size() != 0);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_sample = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, result_valid, sum, sumsq, s_min, s_max}
        !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b rv=%b %0d %0d",
        busy, done, result_valid, sum, sumsq);
    end
    rst = 1'b0;
    idle(3);
    tests++;
    if ({busy, result_valid, sum, sumsq, s_min, s_max} !== '0) begin
      fails++;
      $display("FAIL idle_hold: got busy=%b rv=%b sum=%0d, want zeros",
        busy, result_valid, sum);
    end
  endtask

  task automatic test_single_batch;
    bit ok;
    res_t o, e;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < BATCH; i++) step(1'b0, 1'b1, 13'h0200);
    wait_obs(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL s1_done: no done seen, want done pulse");
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL s1_model: got %s want %s", fmt(o), fmt(e));
      end
      tests++;
      if (int'(o.sum) != 8192 || o.sumsq !== 29'd4194304 ||
          o.mn !== 13'h0200 || o.mx !== 13'h0200) begin
        fails++;
        $display("FAIL s1_const: got %s want 8192/4194304/0200/0200",
          fmt(o));
      end
    end
    idle(4);
    tests++;
    if (obs_q.size() != 0 || result_valid !== 1'b1) begin
      fails++;
      $display("FAIL s1_once: extra done=%0d rv=%b, want 0 and 1",
        obs_q.size(), result_valid);
    end
  endtask

  task automatic test_negative_max;
    bit ok;
    res_t o, e;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < BATCH; i++) step(1'b0, 1'b1, 13'h1000);
    wait_obs(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL s2_done: no done seen, want done pulse");
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL s2_model: got %s want %s", fmt(o), fmt(e));
      end
      tests++;
      if (int'(o.sum) != -65536 || o.sumsq !== 29'd268435456 ||
          o.mn !== 13'h1000 || o.mx !== 13'h1000) begin
        fails++;
        $display("FAIL s2_const: got %s want -65536/268435456/1000/1000",
          fmt(o));
      end
    end
    idle(2);
  endtask

  task automatic test_gaps;
    bit ok;
    res_t o, e;
    busy_err = 0;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < BATCH; i++) begin
      repeat ($urandom_range(0, 3))
        step(1'b0, 1'b0, 13'($urandom_range(0, 8191)));
      step(1'b0, 1'b1, (i % 2 == 0) ? 13'h0100 : 13'h1F00);
    end
    wait_obs(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL s3_done: no done seen, want done pulse");
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL s3_model: got %s want %s", fmt(o), fmt(e));
      end
      tests++;
      if (int'(o.sum) != 0 || o.sumsq !== 29'd1048576 ||
          o.mn !== 13'h1F00 || o.mx !== 13'h0100) begin
        fails++;
        $display("FAIL s3_const: got %s want 0/1048576/1f00/0100",
          fmt(o));
      end
    end
    tests++;
    if (busy_err != 0) begin
      fails++;
      $display("FAIL s3_busy: got %0d busy mismatches, want 0",
        busy_err);
    end
    idle(2);
  endtask

  task automatic test_ignored_inputs;
    bit ok;
    res_t o, e;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 13'h0200);
    step(1'b1, 1'b1, 13'h0200);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 13'h0200);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 13'h0555);
    wait_obs(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL s4_done: no done seen, want done pulse");
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL s4_model: got %s want %s", fmt(o), fmt(e));
      end
      tests++;
      if (int'(o.sum) != 8192 || o.sumsq !== 29'd4194304 ||
          o.mn !== 13'h0200 || o.mx !== 13'h0200) begin
        fails++;
        $display("FAIL s4_const: got %s want 8192/4194304/0200/0200",
          fmt(o));
      end
    end
    idle(3);
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL s4_once: got %0d extra done, want 0",
        obs_q.size());
    end
  endtask

  task automatic test_mid_reset;
    bit ok;
    res_t o, e;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, 13'(13'h0123 + i));
    #3 rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, result_valid, sum, sumsq, s_min, s_max}
        !== '0) begin
      fails++;
      $display("FAIL s5_async: got busy=%b sum=%0d sumsq=%0d, want 0",
        busy, sum, sumsq);
    end
    mstate = 0; mcnt = 0;
    exp_q.delete(); obs_q.delete();
    @(posedge clk);
    edges++;
    #1 rst = 1'b0;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < BATCH; i++)
      step(1'b0, 1'b1, 13'($urandom_range(0, 8191)));
    wait_obs(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL s5_done: no done seen, want done pulse");
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL s5_model: got %s want %s", fmt(o), fmt(e));
      end
    end
    idle(2);
  endtask

  task automatic test_restart_from_done;
    bit ok;
    res_t o, e;
    step(1'b1, 1'b1, 13'h0AAA);
    tests++;
    if (result_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL s6_restart: got rv=%b busy=%b, want 0 1",
        result_valid, busy);
    end
    for (int i = 0; i < BATCH; i++) begin
      if ($urandom_range(0, 1) == 0) idle(1);
      step(1'b0, 1'b1, 13'($urandom_range(0, 8191)));
    end
    wait_obs(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL s6_done: no done seen, want done pulse");
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL s6_model: got %s want %s", fmt(o), fmt(e));
      end
    end
    idle(2);
    tests++;
    if (result_valid !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL s6_hold: got rv=%b busy=%b, want 1 0",
        result_valid, busy);
    end
  endtask

  initial begin
    test_reset;
    test_single_batch;
    test_negative_max;
    test_gaps;
    test_ignored_inputs;
    test_mid_reset;
    test_restart_from_done;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
